cp0_unit: RTL

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit -- MIPS-style coprocessor 0 for a 5-stage pipeline.
//
// Registers: SR (12), Cause (13), EPC (14), PRId (15, constant).
// Raises Req combinationally when an enabled interrupt or a synchronous
// exception reaches commit. On that same edge it records the cause,
// the restart PC and EXL.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   A1 / DOut          mfc0 read index / combinational read data
//   A2, DIn, WE        mtc0 write index, data, enable
//   PC, BD, ExcCode    victim instruction PC, delay-slot flag, exception code
//   HWInt              hardware interrupt lines (bit 2 = timer)
//   EXLClr             eret commit, clears EXL
//   Req                redirect fetch to handler / flush pipeline
//   EPCOut             current EPC (eret target)
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam logic [4:0]  IDX_SR    = 5'd12;
  localparam logic [4:0]  IDX_CAUSE = 5'd13;
  localparam logic [4:0]  IDX_EPC   = 5'd14;
  localparam logic [4:0]  IDX_PRID  = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h0000_5038;

  // Only the architecturally visible fields are stored.
  logic [5:0]  im_reg, im_next;
  logic        exl_reg, exl_next;
  logic        ie_reg, ie_next;
  logic        bd_reg, bd_next;
  logic [5:0]  ip_reg, ip_next;
  logic [4:0]  exc_code_reg, exc_code_next;
  logic [31:2] epc_reg, epc_next;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_victim_low;

  assign int_req = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_req = (ExcCode != 5'd0) & ~exl_reg;
  assign Req     = int_req | exc_req;

  assign wr_sr  = WE && (A2 == IDX_SR);
  assign wr_epc = WE && (A2 == IDX_EPC);

  // A delay-slot victim restarts at the branch, one word earlier.
  assign victim_pc = BD ? (PC - 32'd4) : PC;
  // Low two bits are always forced to zero in EPC.
  assign unused_victim_low = ^victim_pc[1:0];

  always_comb begin
    im_next       = im_reg;
    exl_next      = exl_reg;
    ie_next       = ie_reg;
    bd_next       = bd_reg;
    ip_next       = HWInt;
    exc_code_next = exc_code_reg;
    epc_next      = epc_reg;
    if (Req) begin
      // Exception entry wins every software update this cycle.
      exl_next      = 1'b1;
      bd_next       = BD;
      exc_code_next = int_req ? 5'd0 : ExcCode;
      epc_next      = victim_pc[31:2];
    end else begin
      if (wr_sr) begin
        im_next  = DIn[15:10];
        exl_next = DIn[1];
        ie_next  = DIn[0];
      end
      // eret beats a coincident mtc0 on the EXL field only.
      if (EXLClr) begin
        exl_next = 1'b0;
      end
      if (wr_epc) begin
        epc_next = DIn[31:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      im_reg       <= im_next;
      exl_reg      <= exl_next;
      ie_reg       <= ie_next;
      bd_reg       <= bd_next;
      ip_reg       <= ip_next;
      exc_code_reg <= exc_code_next;
      epc_reg      <= epc_next;
    end
  end

  assign sr_word    = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
  assign cause_word = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
  assign EPCOut     = {epc_reg, 2'b00};

  always_comb begin
    DOut = 32'd0;
    case (A1)
      IDX_SR:    DOut = sr_word;
      IDX_CAUSE: DOut = cause_word;
      IDX_EPC:   DOut = EPCOut;
      IDX_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
  end

endmodule
